// File: rtl/bsg_thermometer_pkg.sv
`default_nettype none
// ============================================================================
// Module     : bsg_thermometer_pkg
// Description: Shared types and helpers for the thermometer ramp generator.
//              - state_e     : ramp controller states (IDLE / RAMP)
//              - count_width : bits needed to hold a count of 0..w inclusive
// Revision   : 1.0 - initial release
// ============================================================================
package bsg_thermometer_pkg;

    // One bit is enough for two states; the explicit width keeps the encoding
    // stable when the value is copied into plain logic constants.
    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eRamp = 1'b1
    } state_e;

    // A thermometer of width w can represent w+1 distinct counts (0..w).
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : bsg_thermometer_pkg
`default_nettype wire

// File: rtl/bsg_thermometer_step.sv
`default_nettype none
// ============================================================================
// Module     : bsg_thermometer_step
// Description: Combinational one-bit thermometer step. Moves the code one
//              position up (shift in a 1 at the LSB) or down (shift in a 0
//              at the MSB). At the limits (all ones going up, all zeros going
//              down) the code is returned unchanged and at_limit_o is raised.
// Ports      :
//   thermo_i   in   width_p  current thermometer code
//   up_i       in   1        1 = step up, 0 = step down
//   thermo_o   out  width_p  stepped (or saturated) code
//   at_limit_o out  1        requested step would leave the legal range
// Revision   : 1.0 - initial release
// ============================================================================
module bsg_thermometer_step
    import bsg_thermometer_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] thermo_i,
    input  logic               up_i,
    output logic [width_p-1:0] thermo_o,
    output logic               at_limit_o
);

    localparam logic [width_p-1:0] c_LSB_ONE = width_p'(1);

    logic [width_p-1:0] w_shift_up;
    logic [width_p-1:0] w_shift_dn;

    // Shift-based forms stay legal for every width, including width_p == 1.
    assign w_shift_up = (thermo_i << 1) | c_LSB_ONE;
    assign w_shift_dn = thermo_i >> 1;

    // For a valid code the MSB is set only when full and the LSB is clear
    // only when empty, so a single bit tells whether the step can happen.
    assign at_limit_o = up_i ? thermo_i[width_p-1] : ~thermo_i[0];

    always_comb begin
        thermo_o = thermo_i;
        if (!at_limit_o) begin
            thermo_o = up_i ? w_shift_up : w_shift_dn;
        end
    end

endmodule : bsg_thermometer_step
`default_nettype wire

// File: rtl/bsg_thermometer_ramp.sv
`default_nettype none
// ============================================================================
// Module     : bsg_thermometer_ramp
// Description: Binary-count-to-thermometer generator with a slewed output.
//              A target count is accepted over a valid/ready handshake and the
//              thermometer output walks toward it one bit per step, so only
//              one output bit toggles per step. Intended for thermometer-coded
//              DAC, bias and current-trim banks.
// Parameters :
//   width_p        thermometer width; count range is 0..width_p
//   step_cycles_p  clock cycles per one-bit step (>= 1)
// Ports      :
//   clk_i      in   1        clock
//   reset_n_i  in   1        synchronous reset, active-low
//   v_i        in   1        target valid
//   count_i    in   CW       target count (binary), saturates at width_p
//   ready_o    out  1        can accept a target (idle and out of reset)
//   thermo_o   out  width_p  current code, bits [count_o-1:0] set
//   count_o    out  CW       binary count of thermo_o
//   busy_o     out  1        ramp in progress
//   done_o     out  1        one-cycle pulse: target reached
//   (CW = $clog2(width_p+1))
// Revision   : 1.0 - initial release
// ============================================================================
module bsg_thermometer_ramp
    import bsg_thermometer_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int step_cycles_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  logic [count_width(width_p)-1:0]  count_i,
    output logic                             ready_o,
    output logic [width_p-1:0]               thermo_o,
    output logic [count_width(width_p)-1:0]  count_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int              c_CW        = count_width(width_p);
    localparam logic [c_CW-1:0] c_MAX_COUNT = c_CW'(width_p);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic [0:0]      c_ST_IDLE   = eIdle;
    localparam logic [0:0]      c_ST_RAMP   = eRamp;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [width_p-1:0] r_thermo;
    logic [c_CW-1:0]    r_count;
    logic [c_CW-1:0]    r_tgt;
    logic               r_up;
    logic               r_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_ready;
    logic               w_accept;
    logic [c_CW-1:0]    w_tgt;
    logic               w_tick;
    logic [width_p-1:0] w_thermo_next;
    logic               w_at_limit;
    logic [c_CW-1:0]    w_count_next;
    logic               w_count_bound;
    logic               w_blocked;
    logic               w_last;

    // ready_o is the only unregistered output; it drops immediately with
    // reset so nothing can be accepted on a reset edge.
    assign w_ready  = (r_state == c_ST_IDLE) & reset_n_i;
    assign w_accept = v_i & w_ready;

    // Out-of-range targets clamp to full scale rather than flag an error.
    assign w_tgt = (count_i > c_MAX_COUNT) ? c_MAX_COUNT : count_i;

    // ------------------------------------------------------------------------
    // Step pacing. With one cycle per step every RAMP cycle is a step and no
    // counter exists at all.
    // ------------------------------------------------------------------------
    generate
        if (step_cycles_p > 1) begin : g_step_cnt
            localparam int              c_SW   = $clog2(step_cycles_p);
            localparam logic [c_SW-1:0] c_WRAP = c_SW'(step_cycles_p - 1);

            logic [c_SW-1:0] r_step_cnt;

            always_ff @(posedge clk_i) begin
                if (!reset_n_i) begin
                    r_step_cnt <= '0;
                end else if (w_accept) begin
                    r_step_cnt <= '0;
                end else if (r_state == c_ST_RAMP) begin
                    r_step_cnt <= w_tick ? '0 : r_step_cnt + c_SW'(1);
                end
            end

            assign w_tick = (r_step_cnt == c_WRAP);
        end else begin : g_no_step_cnt
            assign w_tick = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Single-bit shifter shared by both directions
    // ------------------------------------------------------------------------
    bsg_thermometer_step #(
        .width_p (width_p)
    ) u_step (
        .thermo_i   (r_thermo),
        .up_i       (r_up),
        .thermo_o   (w_thermo_next),
        .at_limit_o (w_at_limit)
    );

    assign w_count_next = r_up ? (r_count + c_ONE) : (r_count - c_ONE);

    // Redundant range guard on the binary count: clamping the target makes
    // these unreachable, but a stray target must never wrap the count.
    assign w_count_bound = r_up ? (r_count == c_MAX_COUNT) : (r_count == '0);
    assign w_blocked     = w_at_limit | w_count_bound;

    // A blocked step ends the ramp instead of leaving the block stuck busy.
    assign w_last = w_blocked | (w_count_next == r_tgt);

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state  <= c_ST_IDLE;
            r_thermo <= '0;
            r_count  <= '0;
            r_tgt    <= '0;
            r_up     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_tgt == r_count) begin
                            // Already there: acknowledge without moving.
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_ST_RAMP;
                            r_tgt   <= w_tgt;
                            r_up    <= (w_tgt > r_count);
                        end
                    end
                end
                c_ST_RAMP: begin
                    if (w_tick) begin
                        if (!w_blocked) begin
                            r_thermo <= w_thermo_next;
                            r_count  <= w_count_next;
                        end
                        if (w_last) begin
                            // Going idle here raises ready_o in the same cycle
                            // as done_o, allowing back-to-back targets.
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_o  = w_ready;
    assign thermo_o = r_thermo;
    assign count_o  = r_count;
    assign busy_o   = (r_state == c_ST_RAMP);
    assign done_o   = r_done;

    // ------------------------------------------------------------------------
    // Structural sanity: the code is always exactly count_o low ones.
    // ------------------------------------------------------------------------
    a_thermo_matches_count : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        r_thermo == ~({width_p{1'b1}} << r_count)
    );

    a_done_only_when_idle : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        r_done |-> (r_state == c_ST_IDLE)
    );

endmodule : bsg_thermometer_ramp
`default_nettype wire

// File: tb/tb_bsg_thermometer_ramp.sv
`default_nettype none
// ============================================================================
// Module     : tb_bsg_thermometer_ramp
// Description: Self-checking bench for bsg_thermometer_ramp. Two instances
//              (one and three cycles per step) share clock and reset. A
//              behavioural model tracks each one; a vector table, directed
//              corner sequences and a random phase compare against it.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_bsg_thermometer_ramp;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v1, v3;
    logic [CW-1:0] c1, c3;
    logic          ready1, busy1, done1, ready3, busy3, done3;
    logic [W-1:0]  thermo1, thermo3;
    logic [CW-1:0] count1, count3;

    always #5 clk = ~clk;

    bsg_thermometer_ramp #(.width_p(W), .step_cycles_p(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v1), .count_i(c1),
        .ready_o(ready1), .thermo_o(thermo1), .count_o(count1),
        .busy_o(busy1), .done_o(done1)
    );

    bsg_thermometer_ramp #(.width_p(W), .step_cycles_p(3)) u_dut3 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v3), .count_i(c3),
        .ready_o(ready3), .thermo_o(thermo3), .count_o(count3),
        .busy_o(busy3), .done_o(done3)
    );

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------- model
    // The model counts down the cycles left before the next step and moves
    // an integer position toward the target.
    typedef struct {
        bit busy;
        int cur;
        int tgt;
        int wait_c;
        bit done;
    } mdl_t;

    mdl_t      m1, m3;
    logic [W-1:0] prev1, prev3;
    bit        rst_edge;

    function automatic mdl_t mdl_step(mdl_t m, bit rn, bit v, int c, int s);
        mdl_t n = m;
        int   t;
        n.done = 1'b0;
        if (!rn) begin
            n.busy = 1'b0; n.cur = 0; n.wait_c = 0;
            return n;
        end
        if (m.busy) begin
            n.wait_c = m.wait_c - 1;
            if (n.wait_c == 0) begin
                n.cur = m.cur + ((m.tgt > m.cur) ? 1 : -1);
                if (n.cur == m.tgt) begin
                    n.busy = 1'b0; n.done = 1'b1;
                end else begin
                    n.wait_c = s;
                end
            end
        end else if (v) begin
            t = (c > W) ? W : c;
            if (t == m.cur) n.done = 1'b1;
            else begin
                n.busy = 1'b1; n.tgt = t; n.wait_c = s;
            end
        end
        return n;
    endfunction

    function automatic logic [W-1:0] therm_of(int n);
        logic [W:0] t;
        t = ((W+1)'(1) << n) - (W+1)'(1);
        return t[W-1:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_one(string tag, mdl_t m, logic rdy, logic [W-1:0] th,
                             logic [CW-1:0] cnt, logic bsy, logic dn,
                             logic [W-1:0] prev, bit skip_slew);
        logic [W-1:0] th_inc;
        th_inc = th + W'(1);
        chk({tag, ".thermo"}, 64'(th),  64'(therm_of(m.cur)));
        chk({tag, ".count"},  64'(cnt), 64'(m.cur));
        chk({tag, ".busy"},   64'(bsy), 64'(m.busy));
        chk({tag, ".done"},   64'(dn),  64'(m.done));
        chk({tag, ".ready"},  64'(rdy), 64'(!m.busy && rst_n));
        // Decoder cross-check: popcount of the code is the binary count.
        chk({tag, ".decode"}, 64'($countones(th)), 64'(cnt));
        chk({tag, ".is_thermo"}, 64'((th & th_inc) == '0), 64'(1));
        if (!skip_slew)
            chk({tag, ".slew"}, 64'($countones(th ^ prev) <= 1), 64'(1));
    endtask

    // One clock: model advances on the rising edge, outputs compared on the
    // falling edge; the caller changes inputs only after this returns.
    task automatic cycle();
        @(posedge clk);
        m1 = mdl_step(m1, rst_n, v1, int'(c1), 1);
        m3 = mdl_step(m3, rst_n, v3, int'(c3), 3);
        rst_edge = !rst_n;
        @(negedge clk);
        check_one("d1", m1, ready1, thermo1, count1, busy1, done1, prev1, rst_edge);
        check_one("d3", m3, ready3, thermo3, count3, busy3, done3, prev3, rst_edge);
        prev1 = thermo1;
        prev3 = thermo3;
    endtask

    // Issue a target to the single-cycle instance and wait for done.
    task automatic ramp1_to(int tgt, output int cycles);
        v1 = 1'b1; c1 = CW'(tgt);
        cycle();
        v1 = 1'b0;
        cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle();
            if (done1) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) chk("ramp1_timeout", 64'(0), 64'(1));
    endtask

    // --------------------------------------------------------------- vectors
    typedef struct {
        bit          rn;
        bit          v;
        int          cnt;
        logic [31:0] th;
        int          count;
        bit          busy;
        bit          done;
        bit          ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit v, int cnt, logic [31:0] th,
                                int count, bit busy, bit done, bit ready);
        vec_t r;
        r.rn = rn; r.v = v; r.cnt = cnt; r.th = th; r.count = count;
        r.busy = busy; r.done = done; r.ready = ready;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int chg_cnt;
        logic [W-1:0] exp5 [6];

        rst_n = 1'b0; v1 = 1'b0; c1 = '0; v3 = 1'b0; c3 = '0;
        prev1 = '0; prev3 = '0;
        m1 = '{default: 0}; m3 = '{default: 0};

        // Reset held three cycles with a pending target.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 20, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h0,  0, 0, 0, 1));
        // Ramp 0 -> 5, one step per cycle.
        tbl.push_back(mk(1, 1, 5,  32'h0,  0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h1,  1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h3,  2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h7,  3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'hF,  4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h1F, 5, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0,  32'h1F, 5, 0, 0, 1));
        // Ramp 5 -> 2, then the same target again.
        tbl.push_back(mk(1, 1, 2,  32'h1F, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'hF,  4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h7,  3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  32'h3,  2, 0, 1, 1));
        tbl.push_back(mk(1, 1, 2,  32'h3,  2, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0,  32'h3,  2, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rn; v1 = tbl[i].v; c1 = CW'(tbl[i].cnt);
            cycle();
            chk($sformatf("vec%0d.thermo", i), 64'(thermo1), 64'(tbl[i].th));
            chk($sformatf("vec%0d.count", i),  64'(count1),  64'(tbl[i].count));
            chk($sformatf("vec%0d.busy", i),   64'(busy1),   64'(tbl[i].busy));
            chk($sformatf("vec%0d.done", i),   64'(done1),   64'(tbl[i].done));
            chk($sformatf("vec%0d.ready", i),  64'(ready1),  64'(tbl[i].ready));
        end
        v1 = 1'b0;

        // Full-scale sweep with a saturating target.
        ramp1_to(0, n);
        chk("t4.to_zero_cycles", 64'(n), 64'(2));
        ramp1_to(40, n);
        chk("t4.up_cycles", 64'(n), 64'(32));
        chk("t4.full_thermo", 64'(thermo1), 64'(32'hFFFF_FFFF));
        chk("t4.full_count", 64'(count1), 64'(32));
        ramp1_to(0, n);
        chk("t4.down_cycles", 64'(n), 64'(32));
        chk("t4.zero_thermo", 64'(thermo1), 64'(0));

        // Three cycles per step: changes only at E0+3 and E0+6, ignored
        // pulses in between, and a back-to-back accept on the done cycle.
        exp5[0] = 32'h0; exp5[1] = 32'h0; exp5[2] = 32'h1;
        exp5[3] = 32'h1; exp5[4] = 32'h1; exp5[5] = 32'h3;
        v3 = 1'b1; c3 = CW'(2);
        cycle();
        chk("t5.busy_after_accept", 64'(busy3), 64'(1));
        chg_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            v3 = (k == 2 || k == 4); c3 = CW'(30);
            cycle();
            chk($sformatf("t5.thermo_k%0d", k), 64'(thermo3), 64'(exp5[k-1]));
        end
        chk("t5.done_at_e6", 64'(done3), 64'(1));
        chk("t5.ready_at_e6", 64'(ready3), 64'(1));
        v3 = 1'b1; c3 = CW'(1);
        cycle();
        v3 = 1'b0;
        chk("t5.b2b_accepted", 64'(busy3), 64'(1));
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (done3) begin
                n = k;
                break;
            end
        end
        chk("t5.b2b_cycles", 64'(n), 64'(3));
        chk("t5.b2b_thermo", 64'(thermo3), 64'(1));

        // Reset mid-ramp at count 7.
        v1 = 1'b1; c1 = CW'(20);
        cycle();
        v1 = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (count1 == CW'(7)) begin
                n = 1;
                break;
            end
            cycle();
        end
        chk("t6.reached_7", 64'(n), 64'(1));
        rst_n = 1'b0;
        cycle();
        chk("t6.thermo", 64'(thermo1), 64'(0));
        chk("t6.busy", 64'(busy1), 64'(0));
        chk("t6.done", 64'(done1), 64'(0));
        rst_n = 1'b1;
        cycle();
        chk("t6.no_late_done", 64'(done1), 64'(0));

        // Random targets and gaps, with rare resets.
        for (int i = 0; i < 20000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            v1 = ($urandom_range(0, 3) == 0);
            c1 = CW'($urandom_range(0, 40));
            v3 = ($urandom_range(0, 3) == 0);
            c3 = CW'($urandom_range(0, 40));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bsg_thermometer_ramp
`default_nettype wire
